wb_arbiter_2x1: RTL

Round-robin arbiter that shares one Wishbone slave port between two Wishbone masters. It sits in front of an interconnect slave port or a shared peripheral. Ownership is granted for a whole CYC cycle, including CTI/BTE bursts, and is never preempted. It is the master-side sharing stage for the bus fabric.

---
 rtl/wb_arbiter_2x1_pkg.sv | 13 +
 rtl/wb_arbiter_2x1_if.sv | 31 +++
 rtl/wb_arbiter_2x1_rr_pick2.sv | 18 +
 rtl/wb_arbiter_2x1.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_2x1_pkg.sv
// wb_arbiter_pkg: shared types and helpers for the 2:1 Wishbone arbiter.
//   wb_arb_state_e : arbiter FSM state encoding
//   timeout_width  : width of the optional stall watchdog counter
package wb_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} wb_arb_state_e;

  // Counter must be able to hold values up to and including the limit.
  function automatic int unsigned timeout_width(int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter_2x1_if.sv
// wb_if: classic Wishbone B4 bus bundle.
//   master modport : drives ADR/CTI/BTE/DAT_W/CYC/SEL/STB/WE, receives DAT_R/ACK/ERR
//   slave modport  : mirror image of master
interface wb_if #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
) ();

  logic [WB_ADDR_WIDTH-1:0]   adr;
  logic [2:0]                 cti;
  logic [1:0]                 bte;
  logic [WB_DATA_WIDTH-1:0]   dat_w;
  logic                       cyc;
  logic [WB_DATA_WIDTH/8-1:0] sel;
  logic                       stb;
  logic                       we;
  logic [WB_DATA_WIDTH-1:0]   dat_r;
  logic                       ack;
  logic                       err;

  modport master (
    output adr, cti, bte, dat_w, cyc, sel, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, cti, bte, dat_w, cyc, sel, stb, we,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_arbiter_2x1_rr_pick2.sv
// wb_rr_pick2: combinational two-way round-robin pick.
//   i_req[1:0]   : request vector
//   i_last_owner : index of the most recent owner
//   o_pick_c     : one-hot winner, 00 when nothing requests
module wb_rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic [1:0] o_pick_c
);

  // On contention the requester that did not own last wins.
  always_comb begin
    o_pick_c    = 2'b00;
    o_pick_c[0] = i_req[0] & (~i_req[1] | i_last_owner);
    o_pick_c[1] = i_req[1] & (~i_req[0] | ~i_last_owner);
  end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// wb_arbiter_2x1: round-robin sharing of one Wishbone slave port by two masters.
// Ownership lasts a whole CYC cycle (bursts included) and is never preempted.
//   clk, rst : clock, asynchronous active-high reset
//   m0, m1   : master-facing ports (wb_if.slave)
//   s0       : shared slave port (wb_if.master)
//   gnt      : registered one-hot owner, 00 when idle
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2x1
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        m0,
  wb_if.slave        m1,
  wb_if.master       s0,
  output logic [1:0] gnt
);

  wb_arb_state_e            r_state;
  wb_arb_state_e            w_state_nxt;
  logic                     r_last_owner;
  logic                     w_last_owner_nxt;
  logic [1:0]               r_gnt;
  logic [1:0]               w_gnt_nxt;
  logic [1:0]               w_pick;
  logic                     w_own0;
  logic                     w_own1;
  logic                     w_to_fire;
  logic [WB_ADDR_WIDTH-1:0] w_adr;
  logic [WB_DATA_WIDTH-1:0] w_dat_w;
  logic [WB_DATA_WIDTH-1:0] w_dat_r;

  wb_rr_pick2 u_pick (
    .i_req        ({m1.cyc, m0.cyc}),
    .i_last_owner (r_last_owner),
    .o_pick_c     (w_pick)
  );

  // Reset gating makes the bus quiet in the very cycle rst rises.
  assign w_own0 = (r_state == ARB_OWN0) && !rst;
  assign w_own1 = (r_state == ARB_OWN1) && !rst;
  assign gnt    = r_gnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= 1'b1;
      r_gnt        <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_gnt        <= w_gnt_nxt;
    end
  end

  // Next state: grant from IDLE only, release when the owner drops CYC.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_pick[0])      w_state_nxt = ARB_OWN0;
        else if (w_pick[1]) w_state_nxt = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!m0.cyc) begin
          w_state_nxt      = ARB_IDLE;
          w_last_owner_nxt = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!m1.cyc) begin
          w_state_nxt      = ARB_IDLE;
          w_last_owner_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs: grant decode and the owner-steered datapath.
  always_comb begin
    w_gnt_nxt = 2'b00;
    unique case (w_state_nxt)
      ARB_OWN0: w_gnt_nxt = 2'b01;
      ARB_OWN1: w_gnt_nxt = 2'b10;
      default:  w_gnt_nxt = 2'b00;
    endcase

    w_adr    = '0;
    w_dat_w  = '0;
    s0.cti   = '0;
    s0.bte   = '0;
    s0.sel   = '0;
    s0.cyc   = 1'b0;
    s0.stb   = 1'b0;
    s0.we    = 1'b0;
    if (w_own0) begin
      w_adr   = m0.adr;
      w_dat_w = m0.dat_w;
      s0.cti  = m0.cti;
      s0.bte  = m0.bte;
      s0.sel  = m0.sel;
      s0.cyc  = m0.cyc;
      s0.stb  = m0.cyc & m0.stb & ~w_to_fire;
      s0.we   = m0.we;
    end else if (w_own1) begin
      w_adr   = m1.adr;
      w_dat_w = m1.dat_w;
      s0.cti  = m1.cti;
      s0.bte  = m1.bte;
      s0.sel  = m1.sel;
      s0.cyc  = m1.cyc;
      s0.stb  = m1.cyc & m1.stb & ~w_to_fire;
      s0.we   = m1.we;
    end
    s0.adr   = w_adr;
    s0.dat_w = w_dat_w;

    // Responses reach only a CYC-qualified owner; an aborting owner sees none.
    w_dat_r  = s0.dat_r;
    m0.dat_r = w_own0 ? w_dat_r : '0;
    m1.dat_r = w_own1 ? w_dat_r : '0;
    m0.ack   = w_own0 & m0.cyc & s0.ack & ~w_to_fire;
    m1.ack   = w_own1 & m1.cyc & s0.ack & ~w_to_fire;
    m0.err   = w_own0 & m0.cyc & (s0.err | w_to_fire);
    m1.err   = w_own1 & m1.cyc & (s0.err | w_to_fire);
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = timeout_width(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_stall;

  assign w_stall   = ((w_own0 & m0.cyc & m0.stb) | (w_own1 & m1.cyc & m1.stb))
                     & ~s0.ack & ~s0.err;
  assign w_to_fire = w_stall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Stall watchdog: counts unanswered strobe cycles of the current owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_to_cnt <= '0;
    else if (!w_stall || w_to_fire) r_to_cnt <= '0;
    else                           r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  logic w_unused_timeout;

  assign w_to_fire        = 1'b0;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

endmodule
